// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 slave exposing a burst-addressed register file.
// All SPI pins are resynchronised into clk; protocol logic runs on the synchronised copies.
module spi_reg_slave #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    localparam int NUM_REGS   = 2 ** ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spi_sck,
    input  logic                         spi_mosi,
    input  logic                         spi_cs_n,
    output logic                         spi_miso,
    output logic                         miso_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr
);
    localparam int SW = DATA_W > 8 ? DATA_W : 8;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
    logic [SYNC_STAGES:0]   vld_q, vld_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   csn_prev_q, csn_prev_d;
    state_t                 state_q, state_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [SW-2:0]          shin_q, shin_d;
    logic                   is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DATA_W-1:0]      miso_sr_q, miso_sr_d;
    logic                   miso_q, miso_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;

    logic              sck_s, mosi_s, csn_s, rise, fall;
    logic [SW-1:0]     shin_next;
    logic [ADDR_W-1:0] ptr_inc;

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign rise      = !sck_prev_q && sck_s;
    assign fall      = sck_prev_q && !sck_s;
    assign shin_next = {shin_q, mosi_s};
    assign ptr_inc   = ptr_q + 1'b1;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        vld_d       = {vld_q[SYNC_STAGES-1:0], 1'b1};
        sck_prev_d  = sck_s;
        csn_prev_d  = csn_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shin_d      = shin_q;
        is_wr_d     = is_wr_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        miso_sr_d   = miso_sr_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        if (csn_s) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else if (state_q == IDLE) begin
            // vld_q top bit: csn_prev_q holds a real pin sample, not a reset value
            if (vld_q[SYNC_STAGES] && csn_prev_q) begin
                state_d   = CMD;
                bit_cnt_d = '0;
            end
        end else if (state_q == CMD) begin
            if (rise) begin
                shin_d    = shin_next[SW-2:0];
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd7) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    is_wr_d   = shin_next[7];
                    ptr_d     = shin_next[ADDR_W-1:0];
                    miso_sr_d = regs_q[shin_next[ADDR_W-1:0]];
                end
            end
        end else begin
            if (rise) begin
                shin_d    = shin_next[SW-2:0];
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'(DATA_W - 1)) begin
                    bit_cnt_d = '0;
                    ptr_d     = ptr_inc;
                    if (is_wr_q) begin
                        regs_d[ptr_q] = shin_next[DATA_W-1:0];
                        wr_strobe_d   = 1'b1;
                        wr_addr_d     = ptr_q;
                    end else begin
                        miso_sr_d = regs_q[ptr_inc];
                    end
                end
            end else if (fall && bit_cnt_q != '0) begin
                // no shift on the fall right after a load, so the MSB survives to the next rise
                miso_sr_d = miso_sr_q << 1;
            end
        end
        miso_d = (state_d == DATA && !is_wr_d) ? miso_sr_d[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '1;
            vld_q       <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shin_q      <= '0;
            is_wr_q     <= 1'b0;
            ptr_q       <= '0;
            regs_q      <= '0;
            miso_sr_q   <= '0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            csn_sync_q  <= csn_sync_d;
            vld_q       <= vld_d;
            sck_prev_q  <= sck_prev_d;
            csn_prev_q  <= csn_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shin_q      <= shin_d;
            is_wr_q     <= is_wr_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            miso_sr_q   <= miso_sr_d;
            miso_q      <= miso_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign spi_miso  = miso_q;
    assign miso_oe   = !csn_s;
    assign reg_out   = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
endmodule
